ysyx_23060208_rd_arbiter: RTL and testbench

Two-master read arbiter that shares one AXI4-Lite-style read port (instruction/data SRAM) between IFU (instruction fetch) and LSU (data load). Sits between the IFU/LSU read channels and the memory slave. Grants one complete AR+R transaction at a time, with at most one outstanding transaction system-wide.

---
 rtl/ysyx_23060208_rd_arbiter_pkg.sv | 23 ++
 rtl/ysyx_23060208_rd_arbiter_pick.sv | 26 ++
 rtl/ysyx_23060208_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060208_rd_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_rd_arbiter_pkg.sv
// Shared definitions for the IFU/LSU read arbiter: FSM state encodings,
// master IDs and the response width.
package ysyx_23060208_rd_arbiter_pkg;

    localparam int ARB_RESP_WIDTH = 2;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR_IFU = 3'd1,
        ST_AR_LSU = 3'd2,
        ST_R_IFU  = 3'd3,
        ST_R_LSU  = 3'd4
    } arb_state_e;

    // Address-phase state that serves the given master.
    function automatic arb_state_e ar_state_of(input logic id);
        return id ? ST_AR_LSU : ST_AR_IFU;
    endfunction

endpackage

// File: rtl/ysyx_23060208_rd_arbiter_pick.sv
// Two-way grant selector. req[0] = IFU, req[1] = LSU.
// ARB_ROUND_ROBIN_EN: ties go to the master that was not served last.
// Otherwise fixed priority, LSU wins ties.
module ysyx_23060208_arb_pick
    import ysyx_23060208_rd_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       last,
`endif
    input  logic [1:0] req,
    output logic       grant_id,
    output logic       any
);

    // Pick a winner among the current requesters.
    always_comb begin
        any = |req;
`ifdef ARB_ROUND_ROBIN_EN
        if (&req) grant_id = ~last;
        else      grant_id = req[1] ? MST_LSU : MST_IFU;
`else
        grant_id = req[1] ? MST_LSU : MST_IFU;
`endif
    end

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Read arbiter sharing one memory read port between IFU and LSU.
// One complete AR+R transaction at a time; handshakes pass through
// combinationally, only the owner state is registered.
// ARB_ROUND_ROBIN_EN: alternate ties using the last-served master;
// undefined: LSU always wins ties.
//
// state     | meaning
// ----------|---------------------------------------------
// IDLE      | no owner, all valid/ready outputs low
// AR_IFU    | IFU owns the port, address phase
// AR_LSU    | LSU owns the port, address phase
// R_IFU     | IFU owns the port, waiting for read data
// R_LSU     | LSU owns the port, waiting for read data
module ysyx_23060208_rd_arbiter
    import ysyx_23060208_rd_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = ARB_RESP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [RESP_WIDTH-1:0] ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    input  logic [DATA_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [RESP_WIDTH-1:0] lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_WIDTH-1:0] mem_araddr,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [RESP_WIDTH-1:0] mem_rresp,
    input  logic                  mem_rvalid,
    output logic                  mem_rready
);

    arb_state_e state_q, state_d;
    logic       pick_id;
    logic       pick_any;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    ysyx_23060208_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .last     (last_q),
`endif
        .req      ({lsu_arvalid, ifu_arvalid}),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    // State register; last-served starts at LSU so IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= MST_LSU;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next state: grant in IDLE, advance on AR and R handshakes.
    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) state_d = ar_state_of(pick_id);
            end
            ST_AR_IFU: begin
                if (ifu_arvalid && mem_arready) begin
                    state_d = ST_R_IFU;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = MST_IFU;
`endif
                end
            end
            ST_AR_LSU: begin
                if (lsu_arvalid && mem_arready) begin
                    state_d = ST_R_LSU;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = MST_LSU;
`endif
                end
            end
            ST_R_IFU: begin
                if (mem_rvalid && ifu_rready) state_d = ST_IDLE;
            end
            ST_R_LSU: begin
                if (mem_rvalid && lsu_rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output routing: only the owner sees handshakes; data/resp are unqualified.
    always_comb begin
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        ifu_rdata   = mem_rdata;
        lsu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        lsu_rresp   = mem_rresp;
        case (state_q)
            ST_AR_IFU: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
            end
            ST_AR_LSU: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
            end
            ST_R_IFU: begin
                ifu_rvalid = mem_rvalid;
                mem_rready = ifu_rready;
            end
            ST_R_LSU: begin
                lsu_rvalid = mem_rvalid;
                mem_rready = lsu_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter. Memory slave and masters are
// driven directly; outputs are sampled 1 ns after the falling edge.
module tb_ysyx_23060208_rd_arbiter;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic TIE_FIRST = IFU;
    localparam bit   RR        = 1'b1;
`else
    localparam logic TIE_FIRST = LSU;
    localparam bit   RR        = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, mem_araddr, mem_rdata;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp, mem_rresp;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_23060208_rd_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_araddr  (ifu_araddr),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .lsu_araddr  (lsu_araddr),
        .lsu_arvalid (lsu_arvalid),
        .lsu_arready (lsu_arready),
        .lsu_rdata   (lsu_rdata),
        .lsu_rresp   (lsu_rresp),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hs"}, {26'd0, mem_arvalid, mem_rready, ifu_arready,
                           lsu_arready, ifu_rvalid, lsu_rvalid}, 32'd0);
        chk({tag, "_addr"}, mem_araddr, 32'd0);
    endtask

    // Entered in AR_<who>: zero-wait address and data handshakes, back in IDLE.
    task automatic run_txn(input logic who, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] resp,
                           input logic drop);
        mem_arready = 1'b1;
        #1;
        chk("ar_addr", mem_araddr, addr);
        chk("ar_valid", {31'd0, mem_arvalid}, 32'd1);
        chk("own_arready", {31'd0, who ? lsu_arready : ifu_arready}, 32'd1);
        chk("oth_arready", {31'd0, who ? ifu_arready : lsu_arready}, 32'd0);
        step();
        mem_arready = 1'b0;
        if (drop) begin
            if (who) lsu_arvalid = 1'b0;
            else     ifu_arvalid = 1'b0;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        mem_rresp  = resp;
        #1;
        chk("r_arvalid", {31'd0, mem_arvalid}, 32'd0);
        chk("own_rvalid", {31'd0, who ? lsu_rvalid : ifu_rvalid}, 32'd1);
        chk("oth_rvalid", {31'd0, who ? ifu_rvalid : lsu_rvalid}, 32'd0);
        chk("own_rdata", who ? lsu_rdata : ifu_rdata, data);
        chk("own_rresp", {30'd0, who ? lsu_rresp : ifu_rresp}, {30'd0, resp});
        chk("r_rready", {31'd0, mem_rready}, 32'd1);
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic exp_who;
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        mem_arready = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rvalid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_idle("reset");

        // IFU alone, one wait cycle on arready and on rvalid: 5 cycles.
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        #1;
        chk_idle("t1_grant_lat");
        step();
        #1;
        chk("t1_arvalid", {31'd0, mem_arvalid}, 32'd1);
        chk("t1_araddr", mem_araddr, 32'h8000_0000);
        chk("t1_arready_wait", {31'd0, ifu_arready}, 32'd0);
        step();
        mem_arready = 1'b1;
        #1;
        chk("t1_arready", {31'd0, ifu_arready}, 32'd1);
        step();
        ifu_arvalid = 1'b0; mem_arready = 1'b0;
        #1;
        chk("t1_rwait_rvalid", {31'd0, ifu_rvalid}, 32'd0);
        chk("t1_rwait_rready", {31'd0, mem_rready}, 32'd1);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413; mem_rresp = 2'b00;
        #1;
        chk("t1_rvalid", {31'd0, ifu_rvalid}, 32'd1);
        chk("t1_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk_idle("t1_done");

        // Simultaneous requests straight after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifu_araddr = 32'h8000_0100; lsu_araddr = 32'h8000_2000;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        step();
        run_txn(TIE_FIRST, TIE_FIRST ? 32'h8000_2000 : 32'h8000_0100,
                32'h0000_0011, 2'b00, 1'b1);
        #1;
        chk_idle("t2_gap");
        step();
        run_txn(~TIE_FIRST, TIE_FIRST ? 32'h8000_0100 : 32'h8000_2000,
                32'h0000_0022, 2'b01, 1'b1);

        // Both masters requesting continuously.
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_who = RR ? ((i % 2) == 1) : LSU;
            step();
            run_txn(exp_who, exp_who ? 32'h8000_2000 : 32'h8000_0100,
                    32'h0000_0100 + i, 2'b00, 1'b0);
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        #1;
        chk_idle("t3_done");

        // Memory stalls arready for 4 cycles; owner drops arvalid once.
        ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            ifu_arvalid = (c != 2);
            #1;
            chk("t4_arvalid", {31'd0, mem_arvalid}, {31'd0, c != 2});
            chk("t4_araddr", mem_araddr, 32'h8000_0040);
            chk("t4_arready", {31'd0, ifu_arready}, 32'd0);
            step();
        end
        ifu_arvalid = 1'b1;
        run_txn(IFU, 32'h8000_0040, 32'h0000_0044, 2'b00, 1'b1);

        // Owner back-pressures read data for 3 cycles; SLVERR passed through.
        lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1;
        step();
        mem_arready = 1'b1;
        #1;
        chk("t5_arready", {31'd0, lsu_arready}, 32'd1);
        step();
        mem_arready = 1'b0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t5_rvalid", {31'd0, lsu_rvalid}, 32'd1);
            chk("t5_rready_hold", {31'd0, mem_rready}, 32'd0);
            chk("t5_rresp", {30'd0, lsu_rresp}, 32'd2);
            step();
        end
        lsu_rready = 1'b1;
        #1;
        chk("t5_rready", {31'd0, mem_rready}, 32'd1);
        chk("t5_rdata", lsu_rdata, 32'hDEAD_BEEF);
        step();
        mem_rvalid = 1'b0; mem_rresp = 2'b00;
        #1;
        chk_idle("t5_done");

        // Reset while LSU waits for data.
        lsu_arvalid = 1'b1;
        step();
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0; lsu_arvalid = 1'b0;
        #1;
        chk("t6_in_r", {31'd0, mem_rready}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk_idle("t6_after_rst");
        mem_rvalid = 1'b0;
        ifu_araddr = 32'h8000_0080; ifu_arvalid = 1'b1;
        step();
        run_txn(IFU, 32'h8000_0080, 32'h0000_0088, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
